// File: rtl/bubsys_prom_loader_pkg.sv
// Shared types and region map for the BubSys PROM download sequencer.
// Regions are packed little-end first: element 0 is the first region in the stream.
package bubsys_prom_loader_pkg;

   localparam int NREG_DEF = 4;
   localparam int MAX_NREG = 8;

   typedef logic [15:0] len_t;

   // Unused tail entries stay zero; only the first NREG entries are consulted.
   localparam len_t [MAX_NREG-1:0] REGION_LEN = {
      16'd0, 16'd0, 16'd0, 16'd0,
      16'd256, 16'd256, 16'd2048, 16'd8192
   };

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int REG_W = idx_w(NREG_DEF);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
      S_FULL,
      S_DONE
   } state_t;

endpackage

// File: rtl/bubsys_prom_loader_if.sv
// Download stream + PROM programming bus between host side and the loader.
// master = host/board side, slave = loader.
interface bubsys_prom_loader_if #(
   parameter int AW   = 14,
   parameter int NREG = 4
);
   logic            i_DL_START;
   logic            i_DL_VALID;
   logic [7:0]      i_DL_DATA;
   logic            o_DL_READY;
   logic            i_DL_END;
   logic [AW-1:0]   o_PROG_ADDR;
   logic [7:0]      o_PROG_DIN;
   logic [NREG-1:0] o_PROG_CS;
   logic            o_PROG_WR;
   logic            o_BUSY;
   logic            o_DONE;
   logic            o_SHORT;
   logic            o_OVERFLOW;
   logic [15:0]     o_CSUM;

   modport master (
      output i_DL_START, i_DL_VALID, i_DL_DATA, i_DL_END,
      input  o_DL_READY, o_PROG_ADDR, o_PROG_DIN, o_PROG_CS, o_PROG_WR,
             o_BUSY, o_DONE, o_SHORT, o_OVERFLOW, o_CSUM
   );

   modport slave (
      input  i_DL_START, i_DL_VALID, i_DL_DATA, i_DL_END,
      output o_DL_READY, o_PROG_ADDR, o_PROG_DIN, o_PROG_CS, o_PROG_WR,
             o_BUSY, o_DONE, o_SHORT, o_OVERFLOW, o_CSUM
   );
endinterface

// File: rtl/bubsys_prom_loader_csum.sv
// 16-bit wrap-around byte accumulator with synchronous clear.
module bubsys_prom_loader_csum (
   input  logic        i_MCLK,
   input  logic        i_RST_n,
   input  logic        i_CLR,
   input  logic        i_ADD,
   input  logic [7:0]  i_DATA,
   output logic [15:0] o_SUM
);
   logic [15:0] r_sum;

   always_ff @(posedge i_MCLK) begin
      if (!i_RST_n || i_CLR)
         r_sum <= '0;
      else if (i_ADD)
         r_sum <= r_sum + {8'd0, i_DATA};
   end

   assign o_SUM = r_sum;
endmodule

// File: rtl/bubsys_prom_loader.sv
// Splits a host byte stream into consecutive PROM regions, one write per byte.
// Define BUBSYS_PROM_LOADER_CSUM_EN to build the checksum accumulator.
module bubsys_prom_loader
   import bubsys_prom_loader_pkg::*;
#(
   parameter int                   AW           = 14,
   parameter int                   NREG         = NREG_DEF,
   parameter int                   WR_HOLD      = 1,
   parameter len_t [MAX_NREG-1:0]  P_REGION_LEN = REGION_LEN
) (
   input  logic                  i_MCLK,
   input  logic                  i_RST_n,
   bubsys_prom_loader_if.slave   bus
);
   localparam int       RW      = idx_w(NREG);
   localparam logic [3:0] HOLD_M1 = 4'(WR_HOLD - 1);

   state_t          r_state;
   logic [RW-1:0]   r_region;
   logic [AW-1:0]   r_addr;
   logic [7:0]      r_din;
   logic [NREG-1:0] r_cs;
   logic            r_wr;
   logic [3:0]      r_hold;
   logic            r_end_pend;
   logic            r_ready;
   logic            r_busy;
   logic            r_done;
   logic            r_short;
   logic            r_ovf;

   logic [AW-1:0]   w_len_m1;
   logic            w_last_addr;
   logic            w_last_reg;
   logic            w_accept;
   logic [15:0]     w_csum;

   always_comb begin
      w_len_m1 = '0;
      for (int k = 0; k < NREG; k++)
         if (r_region == RW'(k)) w_len_m1 = AW'(P_REGION_LEN[k] - 16'd1);
   end

   assign w_last_addr = (r_addr == w_len_m1);
   assign w_last_reg  = (r_region == RW'(NREG - 1));
   // r_ready is only ever high in LOAD or FULL, so this is the handshake.
   assign w_accept    = r_ready & bus.i_DL_VALID;

   always_ff @(posedge i_MCLK) begin
      if (!i_RST_n) begin
         r_state    <= S_IDLE;
         r_region   <= '0;
         r_addr     <= '0;
         r_din      <= '0;
         r_cs       <= '0;
         r_wr       <= 1'b0;
         r_hold     <= '0;
         r_end_pend <= 1'b0;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_short    <= 1'b0;
         r_ovf      <= 1'b0;
      end else if (bus.i_DL_START) begin
         r_state    <= S_LOAD;
         r_region   <= '0;
         r_addr     <= '0;
         r_din      <= '0;
         r_cs       <= '0;
         r_wr       <= 1'b0;
         r_hold     <= '0;
         r_end_pend <= 1'b0;
         r_ready    <= 1'b1;
         r_busy     <= 1'b1;
         r_done     <= 1'b0;
         r_short    <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         case (r_state)
            S_LOAD: begin
               if (w_accept) begin
                  r_din      <= bus.i_DL_DATA;
                  r_wr       <= 1'b1;
                  r_cs       <= NREG'(1) << r_region;
                  r_ready    <= 1'b0;
                  r_hold     <= HOLD_M1;
                  r_end_pend <= bus.i_DL_END;
                  r_state    <= S_WRITE;
               end else if (bus.i_DL_END) begin
                  r_state <= S_DONE;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_short <= 1'b1;
               end
            end
            S_WRITE: begin
               if (bus.i_DL_END) r_end_pend <= 1'b1;
               if (r_hold != 4'd0) begin
                  r_hold <= r_hold - 4'd1;
               end else begin
                  r_wr <= 1'b0;
                  r_cs <= '0;
                  if (w_last_addr) begin
                     r_addr <= '0;
                     if (!w_last_reg) r_region <= r_region + RW'(1);
                  end else begin
                     r_addr <= r_addr + AW'(1);
                  end
                  // END seen during the write takes effect once the byte is committed.
                  if (r_end_pend || bus.i_DL_END) begin
                     r_state    <= S_DONE;
                     r_end_pend <= 1'b0;
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                     r_short    <= !(w_last_addr && w_last_reg);
                  end else begin
                     r_ready <= 1'b1;
                     r_state <= (w_last_addr && w_last_reg) ? S_FULL : S_LOAD;
                  end
               end
            end
            S_FULL: begin
               if (w_accept) r_ovf <= 1'b1;
               if (bus.i_DL_END) begin
                  r_state <= S_DONE;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef BUBSYS_PROM_LOADER_CSUM_EN
   logic w_csum_add;
   assign w_csum_add = (r_state == S_LOAD) && w_accept && !bus.i_DL_START;

   bubsys_prom_loader_csum u_csum (
      .i_MCLK  (i_MCLK),
      .i_RST_n (i_RST_n),
      .i_CLR   (bus.i_DL_START),
      .i_ADD   (w_csum_add),
      .i_DATA  (bus.i_DL_DATA),
      .o_SUM   (w_csum)
   );
`else
   assign w_csum = '0;
`endif

   assign bus.o_DL_READY  = r_ready;
   assign bus.o_PROG_ADDR = r_addr;
   assign bus.o_PROG_DIN  = r_din;
   assign bus.o_PROG_CS   = r_cs;
   assign bus.o_PROG_WR   = r_wr;
   assign bus.o_BUSY      = r_busy;
   assign bus.o_DONE      = r_done;
   assign bus.o_SHORT     = r_short;
   assign bus.o_OVERFLOW  = r_ovf;
   assign bus.o_CSUM      = w_csum;
endmodule

// File: tb/tb_bubsys_prom_loader.sv
// Directed bench: NREG=2, regions {4,2}, WR_HOLD=1; write log captured by a negedge monitor.
module tb_bubsys_prom_loader;
   import bubsys_prom_loader_pkg::*;

   localparam int AW   = 14;
   localparam int NREG = 2;
   localparam len_t [MAX_NREG-1:0] TB_LEN = {
      16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd2, 16'd4
   };
`ifdef BUBSYS_PROM_LOADER_CSUM_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif

   typedef logic [7:0]  bq_t[$];
   typedef logic [23:0] eq_t[$];

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   eq_t  wlog;
   logic rdy_log[$];
   int   wr_len = 0;

   always #5 clk = ~clk;

   bubsys_prom_loader_if #(.AW(AW), .NREG(NREG)) bus ();

   bubsys_prom_loader #(
      .AW(AW), .NREG(NREG), .WR_HOLD(1), .P_REGION_LEN(TB_LEN)
   ) dut (
      .i_MCLK  (clk),
      .i_RST_n (rst_n),
      .bus     (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] mk(input logic [1:0] cs, input int a, input logic [7:0] d);
      return {cs, 14'(a), d};
   endfunction

   // Write capture, strobe width and CS gating
   always @(negedge clk) begin
      chk("cs_gate", {31'd0, (bus.o_PROG_CS != '0) && !bus.o_PROG_WR}, 32'd0);
      if (bus.o_PROG_WR) begin
         if (wr_len == 0) wlog.push_back({bus.o_PROG_CS, bus.o_PROG_ADDR, bus.o_PROG_DIN});
         wr_len++;
      end else if (wr_len != 0) begin
         chk("wr_width", wr_len, 1);
         wr_len = 0;
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      bus.i_DL_START = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_DL_START = 1'b0;
      chk("start_ready", {31'd0, bus.o_DL_READY}, 1);
      chk("start_busy", {31'd0, bus.o_BUSY}, 1);
      wlog.delete();
      rdy_log.delete();
   endtask

   task automatic pulse_end();
      @(negedge clk);
      bus.i_DL_END = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_DL_END = 1'b0;
   endtask

   // VALID held high; END rides with the last byte when end_last is set
   task automatic send(input bq_t d, input bit end_last);
      int   i = 0;
      int   cyc = 0;
      logic rdy;
      while (i < d.size() && cyc < 200) begin
         @(negedge clk);
         rdy = bus.o_DL_READY;
         rdy_log.push_back(rdy);
         bus.i_DL_VALID = 1'b1;
         bus.i_DL_DATA  = d[i];
         bus.i_DL_END   = end_last && (i == d.size() - 1) && rdy;
         @(posedge clk);
         if (rdy) i++;
         cyc++;
      end
      if (i < d.size()) chk("send_timeout", i, d.size());
      @(negedge clk);
      bus.i_DL_VALID = 1'b0;
      bus.i_DL_END   = 1'b0;
   endtask

   task automatic chk_log(input string tag, input eq_t exp);
      chk({tag, "_count"}, wlog.size(), exp.size());
      for (int i = 0; i < exp.size() && i < wlog.size(); i++)
         chk(tag, wlog[i], exp[i]);
   endtask

   task automatic chk_flags(input string tag, input bit sh, input bit ov, input logic [15:0] cs);
      chk({tag, "_done"}, {31'd0, bus.o_DONE}, 1);
      chk({tag, "_busy"}, {31'd0, bus.o_BUSY}, 0);
      chk({tag, "_short"}, {31'd0, bus.o_SHORT}, {31'd0, sh});
      chk({tag, "_ovf"}, {31'd0, bus.o_OVERFLOW}, {31'd0, ov});
      chk({tag, "_csum"}, {16'd0, bus.o_CSUM}, {16'd0, CSUM_ON ? cs : 16'h0});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      eq_t full_exp;
      eq_t short_exp;
      eq_t abort_exp;
      int  w;
      full_exp  = '{mk(2'b01, 0, 8'h01), mk(2'b01, 1, 8'h02), mk(2'b01, 2, 8'h03),
                    mk(2'b01, 3, 8'h04), mk(2'b10, 0, 8'h05), mk(2'b10, 1, 8'h06)};
      short_exp = '{mk(2'b01, 0, 8'hAA), mk(2'b01, 1, 8'hBB), mk(2'b01, 2, 8'hCC)};
      abort_exp = '{mk(2'b01, 0, 8'h11)};
      bus.i_DL_START = 1'b0;
      bus.i_DL_VALID = 1'b0;
      bus.i_DL_DATA  = 8'h00;
      bus.i_DL_END   = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_ready", {31'd0, bus.o_DL_READY}, 0);
      chk("rst_busy", {31'd0, bus.o_BUSY}, 0);
      chk("rst_done", {31'd0, bus.o_DONE}, 0);
      chk("rst_wr", {31'd0, bus.o_PROG_WR}, 0);
      chk("rst_addr", {18'd0, bus.o_PROG_ADDR}, 0);
      chk("rst_csum", {16'd0, bus.o_CSUM}, 0);
      rst_n = 1'b1;

      // Full load
      pulse_start();
      send('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 1'b0);
      pulse_end();
      chk_log("full_wr", full_exp);
      chk_flags("full", 1'b0, 1'b0, 16'h0015);

      // Short load
      pulse_start();
      send('{8'hAA, 8'hBB, 8'hCC}, 1'b0);
      pulse_end();
      chk_log("short_wr", short_exp);
      chk_flags("short", 1'b1, 1'b0, 16'h0231);

      // Overflow
      pulse_start();
      send('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}, 1'b0);
      pulse_end();
      chk_log("ovf_wr", full_exp);
      chk_flags("ovf", 1'b0, 1'b1, 16'h0015);

      // Back-to-back timing with END riding on the last byte
      pulse_start();
      send('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 1'b1);
      chk("ready_pattern", {28'd0, rdy_log[0], rdy_log[1], rdy_log[2], rdy_log[3]}, 32'hA);
      w = 0;
      while (!bus.o_DONE && w < 10) begin
         @(negedge clk);
         w++;
      end
      chk("end_valid_done_wait", {31'd0, w < 10}, 1);
      chk_log("tim_wr", full_exp);
      chk_flags("tim", 1'b0, 1'b0, 16'h0015);

      // Reset during the write of byte 3
      pulse_start();
      send('{8'h01, 8'h02, 8'h03}, 1'b0);
      chk("abort_wr_pre", {31'd0, bus.o_PROG_WR}, 1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_wr", {31'd0, bus.o_PROG_WR}, 0);
      chk("abort_cs", {30'd0, bus.o_PROG_CS}, 0);
      chk("abort_busy", {31'd0, bus.o_BUSY}, 0);
      chk("abort_csum", {16'd0, bus.o_CSUM}, 0);
      chk("abort_ready", {31'd0, bus.o_DL_READY}, 0);
      rst_n = 1'b1;
      pulse_start();
      send('{8'h11}, 1'b0);
      repeat (2) @(negedge clk);
      chk_log("restart_wr", abort_exp);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/bubsys_prom_loader.md
# bubsys_prom_loader

Download sequencer that drives the programming ports of the BubSys PROM/PROM_DC instances. Accepts a host byte stream (MiSTer ioctl-style) over a valid/ready handshake, splits it into consecutive PROM regions and emits one write cycle per byte on shared PROG_ADDR/PROG_DIN buses with one-hot chip selects. Sits between the top-level download interface and every PROM in the board model; reports progress, completion and stream-length errors.

## Interface
- AW, 14: width of o_PROG_ADDR; must cover the largest region length.
- NREG, 4: number of PROM regions; width of o_PROG_CS.
- WR_HOLD, 1: cycles o_PROG_WR stays high per byte (1..15).
- i_MCLK  in  1  system clock; sole clock.
- i_RST_n  in  1  reset, synchronous, active-low.
- i_DL_START  in  1  one-cycle pulse: new download begins.
- i_DL_VALID  in  1  i_DL_DATA holds a byte.
- i_DL_DATA  in  8  download byte.
- o_DL_READY  out  1  loader accepts a byte this cycle.
- i_DL_END  in  1  one-cycle pulse: host finished sending.
- o_PROG_ADDR  out  AW  byte address within the selected region.
- o_PROG_DIN  out  8  byte to write.
- o_PROG_CS  out  NREG  one-hot region select, high only with o_PROG_WR.
- o_PROG_WR  out  1  write strobe.
- o_BUSY  out  1  download in progress.
- o_DONE  out  1  download finished; holds until next start or reset.
- o_SHORT  out  1  end arrived before all regions filled.
- o_OVERFLOW  out  1  bytes received after last region full.
- o_CSUM  out  16  byte checksum (see Configuration).

## Operation
- Stream = region 0 bytes, then region 1, ... region NREG-1; region i length REGION_LEN[i] from the package.
- States: IDLE, LOAD, WRITE, FULL, DONE.
- IDLE: READY=0. i_DL_START -> LOAD; region=0, addr=0, flags and checksum cleared, BUSY=1, DONE=0.
- LOAD: READY=1. VALID&READY -> latch byte into PROG_DIN, go WRITE.
- WRITE: WR=1, CS[region]=1 for WR_HOLD cycles, READY=0. After last hold cycle: if addr==REGION_LEN[region]-1, addr=0 and region++; else addr++. If that was the final byte of region NREG-1 -> FULL, else -> LOAD.
- FULL: READY=1 to drain; any accepted byte is discarded and sets OVERFLOW (sticky). i_DL_END -> DONE.
- i_DL_END in LOAD -> DONE; SHORT=1 if any region unfilled. i_DL_END in WRITE is held pending and applied when the write completes (byte accepted with END in same cycle is still written).
- DONE: BUSY=0, DONE=1, READY=0. Bytes ignored.
- i_DL_START in any state restarts exactly as from IDLE; an in-progress write is aborted (WR, CS low next cycle).
- Checksum: 16-bit wrap-around sum of written bytes only (discarded overflow bytes excluded).

## Timing
- Reset (i_RST_n low at an edge): state IDLE; all outputs 0 next cycle, including mid-write.
- Byte accepted at edge n: PROG_ADDR/DIN/CS/WR valid from n+1 through n+WR_HOLD; READY high again at n+WR_HOLD+1. Throughput: one byte per WR_HOLD+1 cycles.
- PROG_ADDR and PROG_DIN stable for the whole WR pulse; change only while WR=0.
- START to READY=1: one cycle. END (in LOAD) to DONE=1: one cycle.

## Configuration
- BUBSYS_PROM_LOADER_CSUM_EN defined: checksum accumulator built, o_CSUM live, valid whenever DONE=1.
- Not defined: no accumulator; o_CSUM tied to 0.

## Structure
- Package bubsys_prom_loader_pkg: NREG default, REGION_LEN constant array, state enum, region-index width.
- Sub-module bubsys_prom_loader_csum: 16-bit accumulator with clear/add enable; instantiated only under BUBSYS_PROM_LOADER_CSUM_EN.

## Test plan
- Bench config NREG=2, REGION_LEN={4,2}, WR_HOLD=1, checksum enabled.
- Full load: START, bytes 01..06 back-to-back, END -> writes CS=01 addr 0..3 data 01..04, CS=10 addr 0..1 data 05..06; DONE=1, SHORT=0, OVERFLOW=0, CSUM=0x0015.
- Short load: START, bytes AA,BB,CC, END -> three writes to region 0 addr 0..2; DONE=1, SHORT=1, CSUM=0x0231.
- Overflow: START, 8 bytes 01..08, END -> six writes only, OVERFLOW=1, CSUM=0x0015.
- Backpressure/timing: VALID held high continuously -> READY pattern 1,0,1,0; each WR pulse exactly 1 cycle; ADDR/DIN unchanged during WR; VALID+END same cycle on byte 6 -> byte written, then DONE.
- Abort: reset low during the WR cycle of byte 3 -> next cycle WR=0, CS=00, BUSY=0, CSUM=0; START again restarts at region 0 addr 0.
